if_id_register: RTL and testbench
=================================

IF_ID_REGISTER -- requirements
Module: if_id_register

Interface
REQ-001 The block SHALL have parameter IMM_PREFIX, default 3'b101, meaning the opCode[4:2] value that marks a two-word instruction whose next fetched word is its immediate.
REQ-002 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port enable  input  1  1 = advance; 0 = stall, hold all state.
REQ-005 The block SHALL have port flush  input  1  discard the held and in-flight instruction (taken branch, jump, return, interrupt).
REQ-006 The block SHALL have port in_pc  input  32  address of the fetched word.
REQ-007 The block SHALL have port in_inst  input  16  fetched word: opCode[15:11], Rs[10:8], Rd[7:5], SHMNT[4:0].
REQ-008 The block SHALL have outputs out_pc 32, opCode 5, Rs 3, Rd 3, SHMNT 5, imm 16: the decoded instruction packet.
REQ-009 The block SHALL have port out_valid  output  1  packet is a real instruction, not a bubble.
REQ-010 The block SHALL have port has_imm  output  1  imm field carries a captured immediate.
REQ-011 The block SHALL have port imm_pending  output  1  high in state WAIT_IMM; fetch uses it to suppress decode of the next word.
REQ-012 The block SHALL have port issued_count  output  16  count of valid packets issued; saturates at 16'hFFFF.

Function
REQ-013 The block SHALL implement FSM states NORMAL and WAIT_IMM; all transitions occur only on rising clk.
REQ-014 In NORMAL with enable=1, flush=0, and in_inst[15:13]!=IMM_PREFIX, the block SHALL register in_pc and the in_inst fields, set out_valid=1 and has_imm=0, and clear imm to 0 (latency 1 cycle).
REQ-015 In NORMAL with enable=1, flush=0, and in_inst[15:13]==IMM_PREFIX, the block SHALL hold in_pc and the fields in internal registers, drive out_valid=0 for that cycle, and go to WAIT_IMM.
REQ-016 In WAIT_IMM with enable=1 and flush=0, the block SHALL register in_inst as imm and output the held pc/fields with out_valid=1 and has_imm=1, and return to NORMAL.
REQ-017 In WAIT_IMM, the immediate word SHALL NOT be decoded as an instruction, even when its own bits match IMM_PREFIX.
REQ-018 With enable=0 and flush=0, the block SHALL hold every output, the internal registers, the state and the counter unchanged.
REQ-019 flush=1 SHALL take priority over enable: next cycle out_valid=0, has_imm=0, state=NORMAL, and any held first word is discarded; out_pc and the fields may keep stale values.
REQ-020 Every cycle with enable=1 and flush=0 that ends with out_valid=1 SHALL increment issued_count by one, saturating at 16'hFFFF.
REQ-021 imm_pending SHALL equal (state==WAIT_IMM) combinationally.
REQ-022 A bubble (out_valid=0) SHALL have opCode=0, Rs=0, Rd=0 and SHMNT=0, so that downstream sees a NOP.

Reset
REQ-023 With reset=1 at a rising edge, the block SHALL drive out_pc=0, opCode/Rs/Rd/SHMNT=0, imm=0, out_valid=0, has_imm=0, issued_count=0, state=NORMAL.
REQ-024 Reset SHALL take priority over flush and enable, including when asserted mid-operation in WAIT_IMM, which discards the held word.
REQ-025 The first packet after reset deassertion SHALL be issued one cycle after the first enabled edge.

Verification
REQ-026 Plain instruction: reset, then in_pc=32'h20, in_inst=16'h0A45, enable=1 -> next cycle out_valid=1, opCode=5'b00001, Rs=3'b010, Rd=3'b010, SHMNT=5'b00101, has_imm=0, issued_count=1.
REQ-027 Two-word instruction: in_inst=16'hA8E0 at pc 32'h21, then 16'h1234 at pc 32'h22 -> cycle 1: out_valid=0, imm_pending=1; cycle 2: out_valid=1, out_pc=32'h21, opCode=5'b10101, imm=16'h1234, has_imm=1.
REQ-028 Stall during WAIT_IMM: drop enable for 3 cycles after the first word -> outputs and imm_pending=1 are held; on re-enable, the immediate is captured correctly.
REQ-029 Flush in WAIT_IMM: flush=1 on the immediate cycle -> out_valid=0, imm_pending=0, issued_count unchanged; next plain word issues normally.
REQ-030 Saturation and reset: force 65535 issues, then 1 more -> issued_count stays 16'hFFFF; reset=1 with enable=1 -> all outputs zero next cycle.

Source files
------------

// File: rtl/if_id_register.sv
// IF/ID pipeline register: decodes 16-bit fetch words into an instruction packet and
// merges two-word instructions with their trailing immediate before issue.
module if_id_register #(
    parameter logic [2:0] IMM_PREFIX = 3'b101
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        flush,
    input  logic [31:0] in_pc,
    input  logic [15:0] in_inst,
    output logic [31:0] out_pc,
    output logic [4:0]  opCode,
    output logic [2:0]  Rs,
    output logic [2:0]  Rd,
    output logic [4:0]  SHMNT,
    output logic [15:0] imm,
    output logic        out_valid,
    output logic        has_imm,
    output logic        imm_pending,
    output logic [15:0] issued_count
);

    typedef enum logic {NORMAL, WAIT_IMM} state_t;

    state_t      state_q, state_d;
    logic [31:0] held_pc_q, held_pc_d;
    logic [15:0] held_inst_q, held_inst_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [4:0]  op_code_q, op_code_d;
    logic [2:0]  rs_q, rs_d;
    logic [2:0]  rd_q, rd_d;
    logic [4:0]  shmnt_q, shmnt_d;
    logic [15:0] imm_q, imm_d;
    logic        out_valid_q, out_valid_d;
    logic        has_imm_q, has_imm_d;
    logic [15:0] issued_count_q, issued_count_d;

    // NOTE: every _d gets a default before any branch, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d        = state_q;
        held_pc_d      = held_pc_q;
        held_inst_d    = held_inst_q;
        out_pc_d       = out_pc_q;
        op_code_d      = op_code_q;
        rs_d           = rs_q;
        rd_d           = rd_q;
        shmnt_d        = shmnt_q;
        imm_d          = imm_q;
        out_valid_d    = out_valid_q;
        has_imm_d      = has_imm_q;
        issued_count_d = issued_count_q;

        if (flush) begin
            // Bubble fields read as a NOP; out_pc is left stale.
            state_d     = NORMAL;
            held_pc_d   = '0;
            held_inst_d = '0;
            op_code_d   = '0;
            rs_d        = '0;
            rd_d        = '0;
            shmnt_d     = '0;
            imm_d       = '0;
            out_valid_d = 1'b0;
            has_imm_d   = 1'b0;
        end else if (enable) begin
            unique case (state_q)
                NORMAL: begin
                    imm_d     = '0;
                    has_imm_d = 1'b0;
                    if (in_inst[15:13] == IMM_PREFIX) begin
                        held_pc_d   = in_pc;
                        held_inst_d = in_inst;
                        op_code_d   = '0;
                        rs_d        = '0;
                        rd_d        = '0;
                        shmnt_d     = '0;
                        out_valid_d = 1'b0;
                        state_d     = WAIT_IMM;
                    end else begin
                        out_pc_d    = in_pc;
                        op_code_d   = in_inst[15:11];
                        rs_d        = in_inst[10:8];
                        rd_d        = in_inst[7:5];
                        shmnt_d     = in_inst[4:0];
                        out_valid_d = 1'b1;
                    end
                end
                WAIT_IMM: begin
                    // The incoming word is data only, whatever its top bits say.
                    out_pc_d    = held_pc_q;
                    op_code_d   = held_inst_q[15:11];
                    rs_d        = held_inst_q[10:8];
                    rd_d        = held_inst_q[7:5];
                    shmnt_d     = held_inst_q[4:0];
                    imm_d       = in_inst;
                    out_valid_d = 1'b1;
                    has_imm_d   = 1'b1;
                    state_d     = NORMAL;
                end
                default: state_d = NORMAL;
            endcase
            if (out_valid_d && issued_count_q != 16'hFFFF) begin
                issued_count_d = issued_count_q + 16'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= NORMAL;
            held_pc_q      <= '0;
            held_inst_q    <= '0;
            out_pc_q       <= '0;
            op_code_q      <= '0;
            rs_q           <= '0;
            rd_q           <= '0;
            shmnt_q        <= '0;
            imm_q          <= '0;
            out_valid_q    <= 1'b0;
            has_imm_q      <= 1'b0;
            issued_count_q <= '0;
        end else begin
            state_q        <= state_d;
            held_pc_q      <= held_pc_d;
            held_inst_q    <= held_inst_d;
            out_pc_q       <= out_pc_d;
            op_code_q      <= op_code_d;
            rs_q           <= rs_d;
            rd_q           <= rd_d;
            shmnt_q        <= shmnt_d;
            imm_q          <= imm_d;
            out_valid_q    <= out_valid_d;
            has_imm_q      <= has_imm_d;
            issued_count_q <= issued_count_d;
        end
    end

    assign out_pc       = out_pc_q;
    assign opCode       = op_code_q;
    assign Rs           = rs_q;
    assign Rd           = rd_q;
    assign SHMNT        = shmnt_q;
    assign imm          = imm_q;
    assign out_valid    = out_valid_q;
    assign has_imm      = has_imm_q;
    assign imm_pending  = (state_q == WAIT_IMM);
    assign issued_count = issued_count_q;

endmodule

// File: tb/tb_if_id_register.sv
// Directed self-checking bench for if_id_register: plain and two-word issue, stalls,
// flushes, counter saturation and reset priority.
module tb_if_id_register;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        flush;
    logic [31:0] in_pc;
    logic [15:0] in_inst;
    logic [31:0] out_pc;
    logic [4:0]  opCode;
    logic [2:0]  Rs;
    logic [2:0]  Rd;
    logic [4:0]  SHMNT;
    logic [15:0] imm;
    logic        out_valid;
    logic        has_imm;
    logic        imm_pending;
    logic [15:0] issued_count;

    int n_cmp = 0;
    int n_err = 0;

    if_id_register dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .flush       (flush),
        .in_pc       (in_pc),
        .in_inst     (in_inst),
        .out_pc      (out_pc),
        .opCode      (opCode),
        .Rs          (Rs),
        .Rd          (Rd),
        .SHMNT       (SHMNT),
        .imm         (imm),
        .out_valid   (out_valid),
        .has_imm     (has_imm),
        .imm_pending (imm_pending),
        .issued_count(issued_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One rising edge, then settle before sampling and re-driving inputs.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_pkt(input string tag, input logic v, input logic [31:0] pc,
                             input logic [4:0] op, input logic [2:0] rs, input logic [2:0] rd,
                             input logic [4:0] sh, input logic [15:0] im, input logic hi,
                             input logic pend, input logic [15:0] cnt);
        check({tag, ".valid"}, 32'(out_valid), 32'(v));
        if (v) check({tag, ".pc"}, out_pc, pc);
        check({tag, ".op"},    32'(opCode), 32'(op));
        check({tag, ".rs"},    32'(Rs), 32'(rs));
        check({tag, ".rd"},    32'(Rd), 32'(rd));
        check({tag, ".sh"},    32'(SHMNT), 32'(sh));
        check({tag, ".imm"},   32'(imm), 32'(im));
        check({tag, ".himm"},  32'(has_imm), 32'(hi));
        check({tag, ".pend"},  32'(imm_pending), 32'(pend));
        check({tag, ".cnt"},   32'(issued_count), 32'(cnt));
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; flush = 1'b0; in_pc = 32'h0; in_inst = 16'h0;
        step(); step();
        check("rst.pc", out_pc, 32'h0);
        check_pkt("rst", 1'b0, 32'h0, 5'h0, 3'h0, 3'h0, 5'h0, 16'h0, 1'b0, 1'b0, 16'd0);

        // Plain instruction 0x0A45
        reset = 1'b0; enable = 1'b1; in_pc = 32'h20; in_inst = 16'h0A45;
        step();
        check_pkt("plain", 1'b1, 32'h20, 5'b00001, 3'b010, 3'b010, 5'b00101, 16'h0, 1'b0, 1'b0, 16'd1);

        // Stall in NORMAL holds everything
        enable = 1'b0; in_pc = 32'hDEAD; in_inst = 16'h7FFF;
        step();
        check_pkt("stall_n", 1'b1, 32'h20, 5'b00001, 3'b010, 3'b010, 5'b00101, 16'h0, 1'b0, 1'b0, 16'd1);

        // Two-word: 0xA8E0 then immediate 0x1234
        enable = 1'b1; in_pc = 32'h21; in_inst = 16'hA8E0;
        step();
        check_pkt("tw1", 1'b0, 32'h0, 5'h0, 3'h0, 3'h0, 5'h0, 16'h0, 1'b0, 1'b1, 16'd1);
        in_pc = 32'h22; in_inst = 16'h1234;
        step();
        check_pkt("tw2", 1'b1, 32'h21, 5'b10101, 3'b000, 3'b111, 5'h0, 16'h1234, 1'b1, 1'b0, 16'd2);

        // Stall 3 cycles in WAIT_IMM, then an immediate that itself looks like a prefix
        in_pc = 32'h30; in_inst = 16'hA8E0;
        step();
        enable = 1'b0; in_inst = 16'hBEEF;
        for (int i = 0; i < 3; i++) begin
            step();
            check_pkt("stall_w", 1'b0, 32'h0, 5'h0, 3'h0, 3'h0, 5'h0, 16'h0, 1'b0, 1'b1, 16'd2);
        end
        enable = 1'b1; in_pc = 32'h31; in_inst = 16'hB123;
        step();
        check_pkt("resume", 1'b1, 32'h30, 5'b10101, 3'b000, 3'b111, 5'h0, 16'hB123, 1'b1, 1'b0, 16'd3);

        // Flush on the immediate cycle
        in_pc = 32'h40; in_inst = 16'hA8E0;
        step();
        check("fl.pend0", 32'(imm_pending), 32'd1);
        flush = 1'b1; in_pc = 32'h41; in_inst = 16'h5678;
        step();
        check_pkt("flush", 1'b0, 32'h0, 5'h0, 3'h0, 3'h0, 5'h0, 16'h0, 1'b0, 1'b0, 16'd3);
        flush = 1'b0; in_pc = 32'h42; in_inst = 16'h0A45;
        step();
        check_pkt("postfl", 1'b1, 32'h42, 5'b00001, 3'b010, 3'b010, 5'b00101, 16'h0, 1'b0, 1'b0, 16'd4);

        // Saturation: count is 4; 65531 more issues reach 0xFFFF, one more must stick
        for (int i = 0; i < 65531; i++) step();
        check("sat.cnt", 32'(issued_count), 32'hFFFF);
        step();
        check("sat.hold", 32'(issued_count), 32'hFFFF);
        check("sat.valid", 32'(out_valid), 32'd1);

        // Reset mid WAIT_IMM wins over enable and discards the held word
        in_pc = 32'h50; in_inst = 16'hA8E0;
        step();
        check("rw.pend", 32'(imm_pending), 32'd1);
        reset = 1'b1; in_pc = 32'h51; in_inst = 16'h1234;
        step();
        check("rw.pc", out_pc, 32'h0);
        check_pkt("rw", 1'b0, 32'h0, 5'h0, 3'h0, 3'h0, 5'h0, 16'h0, 1'b0, 1'b0, 16'd0);

        // First enabled edge after reset issues the next word as a plain instruction
        reset = 1'b0; in_pc = 32'h60; in_inst = 16'h1234;
        step();
        check_pkt("after", 1'b1, 32'h60, 5'b00010, 3'b010, 3'b001, 5'b10100, 16'h0, 1'b0, 1'b0, 16'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
